tensor_host_seq: RTL and testbench
==================================

TENSOR_HOST_SEQ -- requirements
Module: tensor_host_seq

Interface
REQ-001 Parameters SHALL be: SIZE, default 4, matrix dimension; DATAWIDTH, default 14, element width; GAP_CYC, default 5, idle cycles after each matrix load; START_CYC, default 5, start pulse length; TIMEOUT_CYC, default 4096, watchdog limit.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; ports clk (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-003 Command ports SHALL be: cmd_valid in 1 (job request); cmd_relu in 1 (ReLU enable for the job); cmd_ready out 1 (high only in IDLE); done out 1 (one-cycle pulse at job end); err out 1 (one-cycle pulse on timeout).
REQ-004 Source stream SHALL be: in_valid in 1; in_data in DATAWIDTH; in_ready out 1; it carries SIZE*SIZE A words then SIZE*SIZE B words in tensor load order.
REQ-005 Result stream SHALL be: out_valid out 1; out_data out DATAWIDTH; out_ready in 1.
REQ-006 Tensor-side ports SHALL be: t_depth and t_width out $clog2(SIZE)+1; t_data_in out DATAWIDTH; t_wen, t_set, t_relu, t_start, t_ren out 1; t_busy in 1; t_data_out in DATAWIDTH.

Function
REQ-007 The FSM SHALL have states IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, START, WAIT_HI, WAIT_LO, DRAIN, FINISH.
REQ-008 IDLE: cmd_ready=1; on cmd_valid, latch cmd_relu into t_relu and go to LOAD_A next cycle; t_depth=t_width=0 in IDLE and SIZE in all other states.
REQ-009 LOAD_A/LOAD_B: in_ready=1; t_wen=in_valid and t_data_in=in_data combinationally in the same cycle; the element counter increments per in_valid&in_ready; after word SIZE*SIZE-1 go to GAP_A/GAP_B.
REQ-010 t_set SHALL be 0 in LOAD_A and GAP_A and 1 from LOAD_B through GAP_B; t_wen SHALL be 0 in every non-LOAD state; in_ready SHALL be 0 outside LOAD states.
REQ-011 GAP_A/GAP_B SHALL last exactly GAP_CYC cycles, then go to LOAD_B/START respectively.
REQ-012 START SHALL hold t_start=1 for exactly START_CYC cycles, then go to WAIT_HI.
REQ-013 WAIT_HI SHALL advance to WAIT_LO on t_busy=1; WAIT_LO SHALL advance to DRAIN on t_busy=0; if t_busy is already 0 when START ends, the block still waits for a rising busy.
REQ-014 DRAIN: t_data_out has 1-cycle read latency; t_ren=1 in a cycle only if FIFO occupancy plus in-flight reads is below 2 and issued reads < SIZE*SIZE.
REQ-015 Each returned word SHALL be pushed into a 2-entry output FIFO; out_valid=FIFO non-empty, out_data=FIFO head, pop on out_valid&out_ready; no word is dropped or duplicated under any out_ready pattern.
REQ-016 After SIZE*SIZE words have been popped, go to FINISH, pulse done for one cycle, return to IDLE.
REQ-017 Peak drain throughput SHALL be one word per cycle with out_ready held 1; first out_valid appears 2 cycles after entering DRAIN.

Reset
REQ-018 While reset=1, the next edge SHALL force IDLE, clear all counters and the FIFO, and drive t_wen, t_set, t_relu, t_start, t_ren, out_valid, done, err, in_ready to 0, t_depth/t_width/t_data_in to 0; cmd_ready is 1 after reset releases.
REQ-019 Reset asserted mid-job SHALL abort the job within one cycle with no done pulse; cmd_valid sampled in the reset cycle is ignored.

Configuration
REQ-020 With macro TENSOR_HOST_TIMEOUT_EN defined, a watchdog counting cycles in WAIT_HI, WAIT_LO and DRAIN-with-no-return SHALL, on reaching TIMEOUT_CYC, pulse err, deassert all tensor strobes and return to IDLE without done.
REQ-021 Without TENSOR_HOST_TIMEOUT_EN, err SHALL be tied 0 and the block waits indefinitely.

Verification
REQ-022 Full job SIZE=4: A rows {5,2,6,1},{0,6,2,0},{3,8,1,4},{1,8,5,6}, B {7,5,8,0},{1,8,2,6},{9,4,3,8},{5,3,7,9}, model busy 40 cycles -> 16 t_wen words per matrix, t_set flips only after word 16, t_start high 5 cycles, 16 outputs in order, one done.
REQ-023 in_valid toggling every other cycle during loads -> exactly 32 t_wen cycles, data matches input order, gaps still exactly 5 cycles.
REQ-024 out_ready pattern 1,0,0,1 repeating during DRAIN -> 16 words delivered exactly once, t_ren never exceeds 16, FIFO never overflows.
REQ-025 Reset asserted on 7th B word -> next cycle IDLE, all strobes 0, no done; following job completes correctly.
REQ-026 With TENSOR_HOST_TIMEOUT_EN and TIMEOUT_CYC=100, t_busy held 0 -> err pulses once 100 cycles into WAIT_HI, cmd_ready returns to 1.
REQ-027 cmd_relu=1 -> t_relu=1 from LOAD_A through FINISH, 0 in IDLE.

Source files
------------

// File: rtl/tensor_host_seq.sv
// rtl/tensor_host_seq.sv - host-side sequencer that loads, starts and drains a SIZE x SIZE tensor unit (optional watchdog: TENSOR_HOST_TIMEOUT_EN)
module tensor_host_seq #(
  parameter int SIZE        = 4,
  parameter int DATAWIDTH   = 14,
  parameter int GAP_CYC     = 5,
  parameter int START_CYC   = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic                  cmd_relu,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  err,
  input  logic                  in_valid,
  input  logic [DATAWIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATAWIDTH-1:0]  out_data,
  input  logic                  out_ready,
  output logic [$clog2(SIZE):0] t_depth,
  output logic [$clog2(SIZE):0] t_width,
  output logic [DATAWIDTH-1:0]  t_data_in,
  output logic                  t_wen,
  output logic                  t_set,
  output logic                  t_relu,
  output logic                  t_start,
  output logic                  t_ren,
  input  logic                  t_busy,
  input  logic [DATAWIDTH-1:0]  t_data_out
);

  localparam int NUM     = SIZE * SIZE;
  localparam int CW      = $clog2(NUM + 1);
  localparam int CYC_MAX = (GAP_CYC > START_CYC) ? GAP_CYC : START_CYC;
  localparam int YW      = $clog2(CYC_MAX + 1);
  localparam int DW      = $clog2(SIZE) + 1;

  localparam logic [CW-1:0] LAST_WORD  = CW'(NUM - 1);
  localparam logic [CW-1:0] NUM_W      = CW'(NUM);
  localparam logic [YW-1:0] GAP_LAST   = YW'(GAP_CYC - 1);
  localparam logic [YW-1:0] START_LAST = YW'(START_CYC - 1);
  localparam logic [DW-1:0] DIM        = DW'(SIZE);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, START, WAIT_HI, WAIT_LO, DRAIN, FINISH
  } state_t;

  state_t state, state_d;

  logic                 relu_q;
  logic [CW-1:0]        elem_cnt;
  logic [YW-1:0]        cyc_cnt;
  logic [CW-1:0]        rd_cnt;
  logic [CW-1:0]        pop_cnt;
  logic                 rd_pend;
  logic [DATAWIDTH-1:0] fifo_mem [2];
  logic                 fifo_wp;
  logic                 fifo_rp;
  logic [1:0]           fifo_cnt;

  logic       load_st;
  logic       in_fire;
  logic       pop;
  logic       push;
  logic [2:0] occ;
  logic       ren_ok;
  logic       timeout;

  assign load_st   = (state == LOAD_A) || (state == LOAD_B);
  assign in_fire   = load_st && in_valid;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[fifo_rp];
  assign pop       = out_valid && out_ready;
  assign push      = rd_pend;

  // Occupancy the FIFO will have once this cycle's pop and the pending return settle;
  // crediting the pop is what lets the drain sustain one word per cycle.
  assign occ    = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);
  assign ren_ok = (occ < 3'd2) && (rd_cnt < NUM_W);

`ifdef TENSOR_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_active;

  assign wd_active = (state == WAIT_HI) || (state == WAIT_LO) || ((state == DRAIN) && !rd_pend);
  assign timeout   = wd_active && (wd_cnt == WD_LAST);

  // Watchdog: runs while waiting on the tensor, restarts whenever a read word comes back.
  always_ff @(posedge clk) begin
    if (reset || !wd_active) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and all tensor/host strobes, decoded from the current state.
  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    t_wen     = 1'b0;
    t_data_in = '0;
    t_set     = 1'b0;
    t_start   = 1'b0;
    t_ren     = 1'b0;
    t_depth   = DIM;
    t_width   = DIM;
    t_relu    = relu_q;
    done      = 1'b0;
    err       = timeout;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        t_depth   = '0;
        t_width   = '0;
        t_relu    = 1'b0;
        if (cmd_valid) state_d = LOAD_A;
      end
      LOAD_A: begin
        in_ready  = 1'b1;
        t_wen     = in_valid;
        t_data_in = in_data;
        if (in_fire && (elem_cnt == LAST_WORD)) state_d = GAP_A;
      end
      GAP_A: begin
        if (cyc_cnt == GAP_LAST) state_d = LOAD_B;
      end
      LOAD_B: begin
        in_ready  = 1'b1;
        t_wen     = in_valid;
        t_data_in = in_data;
        t_set     = 1'b1;
        if (in_fire && (elem_cnt == LAST_WORD)) state_d = GAP_B;
      end
      GAP_B: begin
        t_set = 1'b1;
        if (cyc_cnt == GAP_LAST) state_d = START;
      end
      START: begin
        t_start = 1'b1;
        if (cyc_cnt == START_LAST) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (t_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!t_busy) state_d = DRAIN;
      end
      DRAIN: begin
        t_ren = ren_ok && !timeout;
        if (pop && (pop_cnt == LAST_WORD)) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Job parameters and per-state counters; load and cycle counters restart on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      relu_q   <= 1'b0;
      elem_cnt <= '0;
      cyc_cnt  <= '0;
    end else begin
      if ((state == IDLE) && cmd_valid) relu_q <= cmd_relu;
      if (state_d != state) begin
        elem_cnt <= '0;
        cyc_cnt  <= '0;
      end else begin
        if (in_fire) elem_cnt <= elem_cnt + 1'b1;
        if ((state == GAP_A) || (state == GAP_B) || (state == START)) cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  // Drain bookkeeping: reads issued, words handed out, and the one-cycle read pipeline flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt  <= '0;
      pop_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= t_ren;
      if (state != DRAIN) begin
        rd_cnt  <= '0;
        pop_cnt <= '0;
      end else begin
        if (t_ren) rd_cnt <= rd_cnt + 1'b1;
        if (pop) pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  // Two-entry result FIFO; emptied on reset and on a watchdog abort.
  always_ff @(posedge clk) begin
    if (reset || timeout) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= t_data_out;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_host_seq.sv
// tb/tb_tensor_host_seq.sv - self-checking bench for tensor_host_seq with a behavioural tensor unit
module tb_tensor_host_seq;

  localparam int SIZE = 4;
  localparam int DW   = 14;
  localparam int GAP  = 5;
  localparam int STC  = 5;
  localparam int TMO  = 100;
  localparam int NUM  = 16;
  localparam int BUSY = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_relu = 1'b0;
  logic          cmd_ready, done, err;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [2:0]    t_depth, t_width;
  logic [DW-1:0] t_data_in;
  logic          t_wen, t_set, t_relu, t_start, t_ren;
  logic          t_busy;
  logic [DW-1:0] t_data_out = '0;

  always #5 clk = ~clk;

  tensor_host_seq #(
    .SIZE(SIZE), .DATAWIDTH(DW), .GAP_CYC(GAP), .START_CYC(STC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_relu(cmd_relu), .cmd_ready(cmd_ready), .done(done), .err(err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .t_depth(t_depth), .t_width(t_width), .t_data_in(t_data_in),
    .t_wen(t_wen), .t_set(t_set), .t_relu(t_relu), .t_start(t_start), .t_ren(t_ren),
    .t_busy(t_busy), .t_data_out(t_data_out)
  );

  typedef struct packed {
    logic                 relu;
    logic                 vmode;
    logic                 rmode;
    logic [31:0][DW-1:0]  words;
    logic [15:0][DW-1:0]  exp;
  } vec_t;

  vec_t vecs [3];

  int total = 0;
  int bad = 0;
  logic [DW-1:0] sbq [$];

  int cyc = 0;
  int wen_a, wen_b, set_bad, wdata_bad, gap_a, gap_b, start_cnt, ren_cnt;
  int done_cnt, err_cnt, relu_bad, pops, first_ren, first_ov, first_pop, last_pop;
  logic [31:0][DW-1:0] cur_words;
  logic cur_relu = 1'b0;
  logic rmode = 1'b0;
  int orph = 0;
  int jobno = 0;

  logic [DW-1:0] ma_arr [16];
  logic [DW-1:0] mb_arr [16];
  logic [DW-1:0] mc [16];
  int ma = 0, mb = 0, rd_idx = 0;
  int busy_cnt = 0;
  bit busy_en = 1'b1;

  assign t_busy = (busy_cnt != 0);

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [15:0][DW-1:0] matmul(input logic [31:0][DW-1:0] w);
    logic [15:0][DW-1:0] r;
    int acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(w[i*4+k]) * int'(w[16+k*4+j]);
        r[i*4+j] = DW'(acc);
      end
    end
    return r;
  endfunction

  task automatic clear_mon();
    wen_a = 0; wen_b = 0; set_bad = 0; wdata_bad = 0; gap_a = 0; gap_b = 0;
    start_cnt = 0; ren_cnt = 0; done_cnt = 0; err_cnt = 0; relu_bad = 0; pops = 0;
    first_ren = -1; first_ov = -1; first_pop = -1; last_pop = -1;
  endtask

  // Behavioural tensor unit: captures A/B, multiplies at start, busy for BUSY cycles, 1-cycle read latency.
  always @(posedge clk) begin
    if (reset) begin
      ma = 0; mb = 0; rd_idx = 0;
      busy_cnt <= 0;
      t_data_out <= '0;
    end else begin
      if (t_wen) begin
        if (!t_set) begin if (ma < 16) ma_arr[ma] = t_data_in; ma++; end
        else begin if (mb < 16) mb_arr[mb] = t_data_in; mb++; end
      end
      if (t_start) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            int acc;
            logic [DW-1:0] r;
            acc = 0;
            for (int k = 0; k < 4; k++) acc += int'(ma_arr[i*4+k]) * int'(mb_arr[k*4+j]);
            r = DW'(acc);
            if (t_relu && r[DW-1]) r = '0;
            mc[i*4+j] = r;
          end
        end
        ma = 0; mb = 0; rd_idx = 0;
        busy_cnt <= busy_en ? BUSY : 0;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end
      if (t_ren) begin
        t_data_out <= (rd_idx < 16) ? mc[rd_idx] : '0;
        rd_idx++;
      end
    end
  end

  // Result-side backpressure: always ready, or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    if (rmode) begin
      out_ready = (orph % 4 == 0) || (orph % 4 == 3);
      orph++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Port monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (t_wen) begin
        if (t_set != ((wen_a + wen_b) >= 16)) set_bad++;
        if ((wen_a + wen_b) < 32 && t_data_in !== cur_words[wen_a+wen_b]) wdata_bad++;
        if (!t_set) wen_a++; else wen_b++;
      end
      if (t_depth != 0 && !t_set && !in_ready && wen_a == 16 && wen_b == 0) gap_a++;
      if (t_set && !in_ready) gap_b++;
      if (t_start) start_cnt++;
      if (t_ren) begin
        ren_cnt++;
        if (first_ren < 0) first_ren = cyc;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (sbq.size() == 0) chk($sformatf("j%0d_unexpected_word", jobno), 1, 0);
        else chk($sformatf("j%0d_word%0d", jobno, pops - 1), int'(out_data), int'(sbq.pop_front()));
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((t_depth != 0) ? (t_relu !== cur_relu) : (t_relu !== 1'b0)) relu_bad++;
    end
  end

  // mode 0: full job, 1: reset on the 7th B word, 2: tensor never raises busy
  task automatic run_job(input int vi, input int mode);
    int k, guard, n, n_err;
    bit ph, hs, aborted, seen;
    jobno++;
    clear_mon();
    cur_words = vecs[vi].words;
    cur_relu  = vecs[vi].relu;
    rmode     = vecs[vi].rmode;
    if (mode == 0) for (int i = 0; i < NUM; i++) sbq.push_back(vecs[vi].exp[i]);
    if (mode == 2) busy_en = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_relu = vecs[vi].relu;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_relu = 1'b0;
    k = 0; guard = 0; ph = 1'b1; aborted = 1'b0;
    while (k < 32 && guard < 400 && !aborted) begin
      in_valid = vecs[vi].vmode ? ph : 1'b1;
      in_data  = cur_words[k];
      @(negedge clk);
      hs = in_valid && in_ready;
      if (mode == 1 && hs && k == 22) begin
        reset = 1'b1;
        cmd_valid = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      if (hs) k++;
      ph = ~ph;
      guard++;
    end
    in_valid = 1'b0;
    if (mode == 1) begin
      reset = 1'b0; cmd_valid = 1'b0;
      chk("abort_reached", aborted, 1);
      @(negedge clk);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_t_wen", t_wen, 0);
      chk("abort_t_set", t_set, 0);
      chk("abort_t_depth", t_depth, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_t_start", t_start, 0);
      repeat (3) @(negedge clk);
      chk("abort_cmd_ignored", cmd_ready, 1);
      repeat (60) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      return;
    end
    chk($sformatf("j%0d_loaded", jobno), k, 32);
    if (mode == 2) begin
      guard = 0;
      while (!t_start && guard < 200) begin @(negedge clk); guard++; end
      while (t_start && guard < 200) begin @(negedge clk); guard++; end
      chk("stall_start_seen", (guard < 200) ? 1 : 0, 1);
      n = 1; n_err = -1;
      while (n <= 150) begin
        if (err && n_err < 0) n_err = n;
        @(negedge clk);
        n++;
      end
`ifdef TENSOR_HOST_TIMEOUT_EN
      chk("timeout_err_cycle", n_err, TMO);
      chk("timeout_err_once", err_cnt, 1);
      chk("timeout_cmd_ready", cmd_ready, 1);
      chk("timeout_t_start", t_start, 0);
`else
      chk("stall_no_err", err_cnt, 0);
      chk("stall_no_ren", ren_cnt, 0);
      chk("stall_still_busy", cmd_ready, 0);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("stall_reset_idle", cmd_ready, 1);
`endif
      chk("stall_no_done", done_cnt, 0);
      busy_en = 1'b1;
      return;
    end
    guard = 0; seen = 1'b0;
    while (!seen && guard < 3000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      guard++;
    end
    chk($sformatf("j%0d_done_seen", jobno), seen, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("j%0d_wen_a", jobno), wen_a, 16);
    chk($sformatf("j%0d_wen_b", jobno), wen_b, 16);
    chk($sformatf("j%0d_set_order", jobno), set_bad, 0);
    chk($sformatf("j%0d_wdata", jobno), wdata_bad, 0);
    chk($sformatf("j%0d_gap_a", jobno), gap_a, GAP);
    chk($sformatf("j%0d_gap_b", jobno), gap_b, GAP);
    chk($sformatf("j%0d_start_len", jobno), start_cnt, STC);
    chk($sformatf("j%0d_ren_cnt", jobno), ren_cnt, 16);
    chk($sformatf("j%0d_pops", jobno), pops, 16);
    chk($sformatf("j%0d_done_cnt", jobno), done_cnt, 1);
    chk($sformatf("j%0d_err_cnt", jobno), err_cnt, 0);
    chk($sformatf("j%0d_relu", jobno), relu_bad, 0);
    chk($sformatf("j%0d_sb_left", jobno), sbq.size(), 0);
    chk($sformatf("j%0d_first_out_lat", jobno), first_ov - first_ren, 2);
    if (!vecs[vi].rmode) chk($sformatf("j%0d_throughput", jobno), last_pop - first_pop, 15);
    chk($sformatf("j%0d_idle", jobno), cmd_ready, 1);
  endtask

  initial begin
    int a0 [16] = '{5,2,6,1, 0,6,2,0, 3,8,1,4, 1,8,5,6};
    int b0 [16] = '{7,5,8,0, 1,8,2,6, 9,4,3,8, 5,3,7,9};
    int c0 [16] = '{96,68,69,69, 24,56,18,52, 58,95,71,92, 90,107,81,142};
    for (int i = 0; i < 16; i++) begin
      vecs[0].words[i]    = DW'(a0[i]);
      vecs[0].words[16+i] = DW'(b0[i]);
      vecs[0].exp[i]      = DW'(c0[i]);
      vecs[2].words[i]    = DW'($urandom_range(0, 15));
      vecs[2].words[16+i] = DW'($urandom_range(0, 15));
    end
    vecs[0].relu = 1'b0; vecs[0].vmode = 1'b0; vecs[0].rmode = 1'b0;
    vecs[1] = vecs[0];
    vecs[1].relu = 1'b1; vecs[1].vmode = 1'b1;
    vecs[2].exp = matmul(vecs[2].words);
    vecs[2].relu = 1'b1; vecs[2].vmode = 1'b0; vecs[2].rmode = 1'b1;
    clear_mon();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_t_depth", t_depth, 0);
    chk("rst_t_width", t_width, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_strobes", {t_wen, t_set, t_relu, t_start, t_ren}, 0);
    chk("rst_done_err", {done, err}, 0);
    @(posedge clk); #1; reset = 1'b0;

    for (int v = 0; v < 3; v++) run_job(v, 0);
    run_job(2, 1);
    run_job(0, 0);
    run_job(1, 2);
    run_job(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
